// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: shared 640x480 VGA timing constants and the display-window
// compare used by the pixel-address counters and the sync timers.
package vga_timing_pkg;

  // Width of every sync-timer value.
  localparam int TIME_W = 10;

  // Horizontal timing in pixel clocks: sync end, back-porch end,
  // display end, total line length.
  localparam int H_SYNC_END       = 96;
  localparam int H_BACK_PORCH_END = 144;
  localparam int H_DISPLAY_END    = 784;
  localparam int H_TOTAL          = 800;

  // Vertical timing in lines: sync end, back-porch end, display end,
  // total frame length.
  localparam int V_SYNC_END       = 2;
  localparam int V_BACK_PORCH_END = 31;
  localparam int V_DISPLAY_END    = 511;
  localparam int V_TOTAL          = 521;

  // Pixel-address widths for the two axes.
  localparam int H_ADDR_W = 10;
  localparam int V_ADDR_W = 9;

  // True when lo <= value < hi (unsigned, TIME_W bits).
  function automatic logic in_window(
    input logic [TIME_W-1:0] value,
    input logic [TIME_W-1:0] lo,
    input logic [TIME_W-1:0] hi
  );
    return (value >= lo) && (value < hi);
  endfunction

endpackage : vga_timing_pkg

// File: rtl/counter.sv
// counter: modulo-(MaxValue+1) up-counter with synchronous clear and a
// combinational terminal-count trigger. Used for the H/V sync timers and as
// the storage behind each pixel-address counter.
module counter #(
  parameter int MaxValue = 799,
  parameter int Size     = 10
) (
  input  logic            CLK,
  input  logic            RESET,
  input  logic            ENABLE,
  input  logic            CLEAR,
  output logic [Size-1:0] TIME_COUNT,
  output logic            TRIGGER_OUT
);

  localparam logic [Size-1:0] MAX_VAL = Size'(MaxValue);

  logic [Size-1:0] count_q;
  logic [Size-1:0] count_d;
  logic            at_max;

  assign at_max = (count_q == MAX_VAL);

  // Next-state: clear beats advance; advance wraps at MaxValue; otherwise hold.
  always_comb begin
    // NOTE: default first so every path assigns count_d and no latch is inferred.
    count_d = count_q;
    if (CLEAR) begin
      count_d = '0;
    end else if (ENABLE) begin
      count_d = at_max ? '0 : count_q + Size'(1);
    end
  end

  // State register with synchronous active-high reset.
  always_ff @(posedge CLK) begin
    // NOTE: non-blocking assignments for state so all flops update together.
    if (RESET) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign TIME_COUNT = count_q;

  // Qualified by ENABLE so a sparse strobe still yields one pulse per wrap.
  assign TRIGGER_OUT = ENABLE && at_max;

endmodule : counter

// File: rtl/pix_counter.sv
// pix_counter: visible-pixel address for one VGA axis, derived from that
// axis' sync-timer value. The address advances on each ENABLE strobe while
// the timer is inside [TimeToBackPorchEnd, TimeToDisplayTimeEnd) and clears
// on any strobe outside it.
// Optional feature: define PIX_COUNTER_ACTIVE_EN to add the registered
// ACTIVE output (window flag aligned with PIXCOUNT).
module pix_counter
  import vga_timing_pkg::*;
#(
  parameter int AddressSize          = 10,
  parameter int TimeToBackPorchEnd   = 143,
  parameter int TimeToDisplayTimeEnd = 783
) (
  input  logic                   CLK,
  input  logic                   RESET,
  input  logic                   ENABLE,
  input  logic [TIME_W-1:0]      SYNCH_TIME,
`ifdef PIX_COUNTER_ACTIVE_EN
  output logic                   ACTIVE,
`endif
  output logic [AddressSize-1:0] PIXCOUNT
);

  localparam logic [TIME_W-1:0] WIN_LO   = TIME_W'(TimeToBackPorchEnd);
  localparam logic [TIME_W-1:0] WIN_HI   = TIME_W'(TimeToDisplayTimeEnd);
  // Wrapping at the all-ones value makes the address count modulo 2^AddressSize.
  localparam int                ADDR_MAX = (1 << AddressSize) - 1;

  logic win;
  logic cnt_en;
  logic cnt_clr;
  logic pix_wrap_unused;

  assign win     = in_window(SYNCH_TIME, WIN_LO, WIN_HI);
  assign cnt_en  = ENABLE && win;
  assign cnt_clr = ENABLE && !win;

  counter #(
    .MaxValue (ADDR_MAX),
    .Size     (AddressSize)
  ) u_addr (
    .CLK         (CLK),
    .RESET       (RESET),
    .ENABLE      (cnt_en),
    .CLEAR       (cnt_clr),
    .TIME_COUNT  (PIXCOUNT),
    .TRIGGER_OUT (pix_wrap_unused)
  );

`ifdef PIX_COUNTER_ACTIVE_EN
  logic active_q;
  logic active_d;

  // Window flag follows the same strobe as the address so both stay aligned.
  always_comb begin
    active_d = active_q;
    if (ENABLE) begin
      active_d = win;
    end
  end

  // Window flag register with synchronous reset.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      active_q <= 1'b0;
    end else begin
      active_q <= active_d;
    end
  end

  assign ACTIVE = active_q;
`endif

endmodule : pix_counter

// File: tb/tb_pix_counter.sv
// tb_pix_counter: randomized and directed self-checking bench for
// pix_counter (default horizontal parameters) and its counter sub-module.
module tb_pix_counter;
  import vga_timing_pkg::*;

  localparam int AW = 10;
  localparam int LO = 143;
  localparam int HI = 783;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // pix_counter stimulus/response
  logic           rst;
  logic           en;
  logic [9:0]     st;
  logic [AW-1:0]  pix;
`ifdef PIX_COUNTER_ACTIVE_EN
  logic           active;
`endif

  pix_counter #(
    .AddressSize          (AW),
    .TimeToBackPorchEnd   (LO),
    .TimeToDisplayTimeEnd (HI)
  ) dut (
    .CLK        (clk),
    .RESET      (rst),
    .ENABLE     (en),
    .SYNCH_TIME (st),
`ifdef PIX_COUNTER_ACTIVE_EN
    .ACTIVE     (active),
`endif
    .PIXCOUNT   (pix)
  );

  // Stand-alone counters for the timer checks
  logic       c_rst;
  logic       c8_en, c8_clr, c8_trig;
  logic [9:0] c8_cnt;
  logic       c5_en, c5_clr, c5_trig;
  logic [9:0] c5_cnt;

  counter #(.MaxValue(799), .Size(10)) u_c800 (
    .CLK (clk), .RESET (c_rst), .ENABLE (c8_en), .CLEAR (c8_clr),
    .TIME_COUNT (c8_cnt), .TRIGGER_OUT (c8_trig)
  );

  counter #(.MaxValue(520), .Size(10)) u_c521 (
    .CLK (clk), .RESET (c_rst), .ENABLE (c5_en), .CLEAR (c5_clr),
    .TIME_COUNT (c5_cnt), .TRIGGER_OUT (c5_trig)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model state
  int m_pix = 0;
  bit m_act = 1'b0;
  int m8 = 0;
  int m5 = 0;

  // One clock of pix_counter: drive at negedge, model at posedge, check at next negedge.
  task automatic pix_step(input bit r, input bit e, input int t);
    bit inside_win;
    rst = r; en = e; st = 10'(t);
    @(posedge clk);
    inside_win = (t >= LO) && (t < HI);
    if (r) begin
      m_pix = 0;
      m_act = 1'b0;
    end else if (e) begin
      m_pix = inside_win ? (m_pix + 1) % (1 << AW) : 0;
      m_act = inside_win;
    end
    @(negedge clk);
    check("pix", 32'(pix), 32'(m_pix));
`ifdef PIX_COUNTER_ACTIVE_EN
    check("active", 32'(active), 32'(m_act));
`endif
  endtask

  // One clock of the MaxValue=799 counter.
  task automatic c8_step(input bit e, input bit clr);
    c8_en = e; c8_clr = clr;
    #1;
    check("c800_trig", 32'(c8_trig), 32'(e && (m8 == 799)));
    @(posedge clk);
    if (c_rst)    m8 = 0;
    else if (clr) m8 = 0;
    else if (e)   m8 = (m8 + 1) % 800;
    @(negedge clk);
    check("c800_cnt", 32'(c8_cnt), 32'(m8));
  endtask

  // One clock of the MaxValue=520 counter; returns the observed trigger.
  task automatic c5_step(input bit e, output bit trig);
    c5_en = e;
    #1;
    trig = c5_trig;
    check("c521_trig", 32'(c5_trig), 32'(e && (m5 == 520)));
    @(posedge clk);
    if (e) m5 = (m5 + 1) % 521;
    @(negedge clk);
    check("c521_cnt", 32'(c5_cnt), 32'(m5));
  endtask

  initial begin
    int trig_cnt;
    int en_since;
    bit tr;
    int t;

    rst = 1'b1; en = 1'b0; st = '0;
    c_rst = 1'b1; c8_en = 1'b0; c8_clr = 1'b0; c5_en = 1'b0; c5_clr = 1'b0;
    @(negedge clk);

    // 1: reset held with an in-window strobe keeps the address at zero
    for (int i = 0; i < 3; i++) pix_step(1'b1, 1'b1, 200);
    check("reset_pix", 32'(pix), 32'd0);

    // 2: full line sweep with a strobe every cycle
    for (int i = 0; i < 800; i++) begin
      pix_step(1'b0, 1'b1, i);
      if (i == 143) check("sweep_first", 32'(pix), 32'd1);
      if (i == 781) check("sweep_639", 32'(pix), 32'd639);
      if (i == 782) check("sweep_640", 32'(pix), 32'd640);
      if (i == 783) check("sweep_clear", 32'(pix), 32'd0);
    end

    // 3: 1-in-2 strobe inside the window
    for (int i = 0; i < 20; i++) pix_step(1'b0, (i % 2) == 0, 300);
    check("strobe_count", 32'(pix), 32'd10);

    // 6: reset mid-window at address 57, then resume from zero
    pix_step(1'b1, 1'b0, 0);
    for (int i = 0; i < 57; i++) pix_step(1'b0, 1'b1, 300);
    check("mid_57", 32'(pix), 32'd57);
    pix_step(1'b1, 1'b1, 300);
    check("mid_reset", 32'(pix), 32'd0);
    pix_step(1'b0, 1'b1, 300);
    check("mid_resume", 32'(pix), 32'd1);

    // Random stimulus, biased towards the window edges
    for (int i = 0; i < 2000; i++) begin
      case ($urandom_range(0, 3))
        0:       t = LO - 2 + int'($urandom_range(0, 3));
        1:       t = HI - 2 + int'($urandom_range(0, 3));
        2:       t = int'($urandom_range(LO, HI - 1));
        default: t = int'($urandom_range(0, 1023));
      endcase
      pix_step($urandom_range(0, 99) == 0, $urandom_range(0, 3) != 0, t);
    end

    // 4: MaxValue=799 counter, enable every cycle
    c8_step(1'b0, 1'b0);
    c_rst = 1'b0;
    trig_cnt = 0;
    for (int i = 0; i < 1700; i++) begin
      c8_step(1'b1, 1'b0);
      if (m8 == 0 && i > 0) trig_cnt++;
    end
    check("c800_wraps", 32'(trig_cnt), 32'd2);
    // Clear and hold behaviour
    for (int i = 0; i < 40; i++) c8_step($urandom_range(0, 1) == 1, $urandom_range(0, 7) == 0);

    // 5: MaxValue=520 counter with a sparse enable pulse
    trig_cnt = 0;
    en_since = 0;
    for (int i = 0; i < 521 * 5 * 3; i++) begin
      c5_step((i % 5) == 4, tr);
      if ((i % 5) == 4) en_since++;
      if (tr) begin
        trig_cnt++;
        check("c521_span", 32'(en_since), 32'd521);
        en_since = 0;
      end
    end
    check("c521_pulses", 32'(trig_cnt), 32'd3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_pix_counter
